// File: rtl/seg_display_scanner.sv
// seg_display_scanner
// Time-multiplexed common-anode 7-segment scanner. One digit is selected per
// slot of TICKS_PER_DIGIT clocks. The first GUARD_TICKS clocks of every slot
// keep all anodes off, so the previous digit cannot ghost into the next one.
// New digit/mask data is double-buffered in shadow registers. The shadow is
// only reloaded at frame boundaries, so a frame never shows mixed data.
// Optional decimal-point support is compiled in when SCAN_DP_EN is defined.
module seg_display_scanner #(
    parameter int N_DIGITS        = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int GUARD_TICKS     = 16,
    parameter int BLINK_FRAMES    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   blank_mask_in,
    input  logic [N_DIGITS-1:0]   blink_mask_in,
`ifdef SCAN_DP_EN
    input  logic [N_DIGITS-1:0]   dp_in,
`endif
    input  logic                  update,
    output logic                  update_ack,
    output logic [3:0]            bcd_out,
    output logic [N_DIGITS-1:0]   anodes,
    output logic                  frame_start
`ifdef SCAN_DP_EN
    ,
    output logic                  dp_out
`endif
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] ALL_OFF = {N_DIGITS{1'b1}};

    // Scan state
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [FRM_W-1:0] frame_cnt_r;
    logic             blink_phase_r;

    // Shadow copy of the display data, stable for a whole frame
    logic [N_DIGITS-1:0][3:0] shadow_digits_r;
    logic [N_DIGITS-1:0]      shadow_blank_r;
    logic [N_DIGITS-1:0]      shadow_blink_r;
`ifdef SCAN_DP_EN
    logic [N_DIGITS-1:0]      shadow_dp_r;
    logic                     dp_s;
`endif

    logic                slot_end_s;
    logic                frame_end_s;
    logic                off_s;
    logic [N_DIGITS-1:0] anodes_s;
    logic [3:0]          bcd_s;

    // Build an active-low one-hot anode word. All anodes stay off when blanked.
    function automatic logic [N_DIGITS-1:0] anode_pattern(
        input logic [IDX_W-1:0] sel,
        input logic             blank
    );
        logic [N_DIGITS-1:0] pat;
        pat = ALL_OFF;
        if (!blank) begin
            pat[sel] = 1'b0;
        end else begin
            pat = ALL_OFF;
        end
        return pat;
    endfunction

    assign slot_end_s  = (cnt_r == CNT_LAST);
    assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

    // Per-slot display decision from the current scan position and shadow data
    always_comb begin
        off_s    = (cnt_r < CNT_GUARD) || shadow_blank_r[idx_r] ||
                   (blink_phase_r && shadow_blink_r[idx_r]);
        anodes_s = anode_pattern(idx_r, off_s);
        bcd_s    = shadow_digits_r[idx_r];
`ifdef SCAN_DP_EN
        if (!off_s && shadow_dp_r[idx_r]) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
`endif
    end

    // Slot prescaler and digit index; the index wraps to 0 after the last digit
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (slot_end_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if (idx_r == IDX_LAST) begin
                idx_r <= {IDX_W{1'b0}};
            end else begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Frame counter; the blink phase flips once every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r   <= {FRM_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (frame_end_s) begin
            if (frame_cnt_r == FRM_LAST) begin
                frame_cnt_r   <= {FRM_W{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + FRM_W'(1);
            end
        end
    end

    // Shadow reload, allowed only on a frame boundary while update is held
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_digits_r <= {N_DIGITS{4'hF}};
            shadow_blank_r  <= {N_DIGITS{1'b0}};
            shadow_blink_r  <= {N_DIGITS{1'b0}};
`ifdef SCAN_DP_EN
            shadow_dp_r     <= {N_DIGITS{1'b0}};
`endif
        end else if (frame_end_s && update) begin
            shadow_digits_r <= digits_in;
            shadow_blank_r  <= blank_mask_in;
            shadow_blink_r  <= blink_mask_in;
`ifdef SCAN_DP_EN
            shadow_dp_r     <= dp_in;
`endif
        end
    end

    // Registered outputs; they lag the scan state by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            anodes      <= ALL_OFF;
            bcd_out     <= 4'hF;
            update_ack  <= 1'b0;
            frame_start <= 1'b0;
`ifdef SCAN_DP_EN
            dp_out      <= 1'b1;
`endif
        end else begin
            anodes      <= anodes_s;
            bcd_out     <= bcd_s;
            update_ack  <= frame_end_s & update;
            frame_start <= frame_end_s;
`ifdef SCAN_DP_EN
            dp_out      <= dp_s;
`endif
        end
    end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexes up to N_DIGITS common-anode 7-segment digits through one shared BCD-to-segment decoder.
- Selects one digit per slot and drives the decoder's 4-bit BCD input and the active-low anode lines.
- Applies per-digit blanking, blinking and an anti-ghosting guard interval.
- Sits between the clock/alarm time-keeping logic (producer of BCD digits) and the board display pins.

Parameters:
- N_DIGITS, 8: number of digits scanned; index width is clog2(N_DIGITS).
- TICKS_PER_DIGIT, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz).
- GUARD_TICKS, 16: cycles at the start of each slot with all anodes off; must be < TICKS_PER_DIGIT.
- BLINK_FRAMES, 64: full frames per blink-phase toggle.

Ports:
- clk, input, 1: system clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- digits_in, input, 4*N_DIGITS: BCD digits; digit i is bits [4i+3:4i]; digit 0 is rightmost.
- blank_mask_in, input, N_DIGITS: 1 = digit permanently off.
- blink_mask_in, input, N_DIGITS: 1 = digit blanked during blink phase 1.
- update, input, 1: level request to load the three *_in buses into the shadow registers.
- update_ack, output, 1: one-cycle pulse; shadow was loaded on this edge.
- bcd_out, output, 4: BCD value of the selected digit, to the segment decoder.
- anodes, output, N_DIGITS: one-hot active-low anode enables (1 = off).
- frame_start, output, 1: one-cycle pulse when the scan index wraps to 0.

Behaviour:
- Reset, applied at any time including mid-frame:
  - Prescaler cnt=0, idx=0, blink_phase=0, frame counter=0.
  - Shadow digits=4'hF each, shadow blank/blink masks=0.
  - anodes=all 1, bcd_out=4'hF, update_ack=0, frame_start=0.
- Prescaler:
  - cnt counts 0..TICKS_PER_DIGIT-1.
  - At terminal count, cnt returns to 0 and idx advances.
  - idx wraps from N_DIGITS-1 to 0.
- Frame boundary: the edge where idx wraps to 0 (end of slot N_DIGITS-1). On that edge:
  - frame_start pulses high for one cycle.
  - The frame counter increments; when it reaches BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
  - If update=1, the shadow registers load digits_in, blank_mask_in and blink_mask_in sampled on that edge, and update_ack pulses high for that same cycle.
- Update handshake:
  - Requester holds update and data stable until it sees update_ack.
  - Loads happen only at frame boundaries, so a displayed frame never mixes old and new data.
  - If update is still high after the ack, the load repeats at the next boundary (harmless).
  - Max ack latency: N_DIGITS*TICKS_PER_DIGIT cycles.
- Displayed output for slot idx, computed combinationally from (idx, cnt, shadow, blink_phase) and registered, so anodes/bcd_out lag internal state by exactly 1 cycle:
  - off = (cnt < GUARD_TICKS) OR shadow_blank[idx] OR (blink_phase AND shadow_blink[idx]).
  - anodes = all 1 if off, else all 1 except bit idx = 0.
  - bcd_out = shadow digit[idx] always; not gated by off, so the decoder input is stable during the guard.
- Invariant: never more than one anode low in any cycle.
- Non-BCD digit values 10..15 pass through unchanged; the decoder shows "-".

Optional Feature:
- Macro SCAN_DP_EN.
- Defined:
  - Adds input dp_in[N_DIGITS] (1 = point lit), shadow-loaded with the other buses under the same handshake.
  - Adds output dp_out (1 bit, active low), registered with the same 1-cycle lag.
  - dp_out = 0 only when the digit is not off and shadow_dp[idx]=1; reset value 1.
- Undefined: no dp ports or registers exist; all other behaviour is identical.

Test Plan:
All scenarios use N_DIGITS=8, TICKS_PER_DIGIT=4, GUARD_TICKS=1, BLINK_FRAMES=2.
- Reset then update=1, digits_in=32'h87654321, masks=0, held until ack:
  - update_ack pulses exactly once, 32 cycles after reset release.
  - Next frame: each slot shows anodes all 1 for 1 cycle, then bit i low for 3 cycles, with bcd_out=i+1.
- Monitor every cycle for a full frame: popcount(~anodes) <= 1; frame_start pulses once per 32 cycles, coincident with update_ack.
- blank_mask_in=8'h0F: anodes[3:0] never go low; anodes[7:4] behave normally; bcd_out still cycles 1..8.
- blink_mask_in=8'h01, no blank: anodes[0] active for 2 frames, inactive for 2 frames, repeating (period 128 cycles).
- Change digits_in to 32'h11111111 mid-frame with update=1 at idx=3: remaining slots of the current frame still show old values; new values appear from idx=0 of the next frame.
- Assert reset at idx=5, cnt=2: the next cycle shows anodes=8'hFF, bcd_out=4'hF, update_ack=0; after release, shadow digits read 4'hF until the next ack.
- With SCAN_DP_EN and dp_in=8'h04: dp_out=0 only during the 3 active cycles of slot 2.
